mult_share_arb: RTL and testbench
=================================

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, NREQ, per-requester multiply request; held high until granted.
REQ-006 SHALL have port a_in, input, NREQ*WIDTH, packed multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port b_in, input, NREQ*WIDTH, packed multipliers; same packing as a_in.
REQ-008 SHALL have port gnt, output, NREQ, one-hot grant pulse, one cycle wide.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port res_valid, output, 1, one-cycle result strobe.
REQ-011 SHALL have port res_data, output, 2*WIDTH, unsigned product, valid while res_valid is high.
REQ-012 SHALL have port res_id, output, clog2(NREQ), index of the requester owning res_data.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with req nonzero, the next edge SHALL select the winner, latch its a/b and index, clear the accumulator and count, pulse gnt[winner] for the following cycle, and enter RUN.
REQ-015 In IDLE with req zero, the FSM SHALL stay in IDLE and all outputs SHALL hold their reset values except res_data and res_id, which hold their last values.
REQ-016 RUN SHALL last exactly WIDTH cycles; on step k (0..WIDTH-1), acc += (b[k] ? a<<k : 0), zero-extended to 2*WIDTH bits with no overflow possible.
REQ-017 On the final RUN edge, the FSM SHALL enter DONE with res_valid=1, and res_data and res_id updated together.
REQ-018 DONE SHALL last one cycle, then return to IDLE with res_valid=0; new arbitration is possible on the following edge.
REQ-019 Latency SHALL be WIDTH+1 edges from the capture edge to res_valid high; maximum throughput SHALL be one product per WIDTH+2 cycles.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_winner+1 modulo NREQ, and the pointer updates only on a grant.
REQ-021 Changes to req, a_in or b_in during RUN/DONE SHALL NOT affect the operation in flight.
REQ-022 A req still high after its own gnt SHALL be treated as a new request at the next IDLE.
REQ-023 An operand of zero SHALL still take the full WIDTH+2 cycles and produce res_data=0.

Reset
REQ-024 On rst, the block SHALL immediately reset to state IDLE, gnt=0, busy=0, res_valid=0, res_data=0, res_id=0, and round-robin pointer NREQ-1 (so requester 0 is first).
REQ-025 A reset asserted mid-RUN SHALL abort the operation with no res_valid for it; the first operation after reset release follows REQ-014.

Configuration
REQ-026 When macro MULT_ARB_PRIO0_EN is defined, requester 0 SHALL win whenever req[0] is high, and the others SHALL be round-robin among themselves.
REQ-027 When MULT_ARB_PRIO0_EN is undefined, all requesters SHALL be pure round-robin per REQ-020.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default WIDTH/NREQ constants.
REQ-029 The shift-add datapath (accumulator, shifted operand, bit counter, done flag) SHALL be one sub-module, mult_seq_core; arbitration and the FSM stay in mult_share_arb.

Verification (WIDTH=4, NREQ=4)
REQ-030 The bench SHALL cover: req=0001, a0=15, b0=15 -> gnt=0001 one cycle later, res_valid 5 edges after capture, res_data=225, res_id=0.
REQ-031 The bench SHALL cover: req=1111 held, ops i*3 x 5 -> grants in order 0,1,2,3,0 and results 0,15,30,45; 6 cycles between res_valid pulses.
REQ-032 The bench SHALL cover: a=9, b=0 and a=0, b=11 -> res_data=0 after full latency, with no early res_valid.
REQ-033 The bench SHALL cover: change a_in/b_in of the granted requester during RUN (7x6 then 1x1) -> res_data=42.
REQ-034 The bench SHALL cover: rst asserted at RUN step 2 -> busy and gnt drop immediately, no res_valid; after release, req=0100 with 3x4 -> res_data=12, res_id=2.
REQ-035 With MULT_ARB_PRIO0_EN, the bench SHALL cover: req=1111 held -> requester 0 wins every arbitration; req=1110 -> round-robin 1,2,3.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Shared types and default sizing for the shared multiplier arbiter.
package mult_share_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_share_arb_seq_core.sv
// Sequential shift-add multiplier datapath (module mult_seq_core): one product bit per cycle,
// LSB of the multiplier first, with a down-counter that flags the final step.
module mult_seq_core
    import mult_share_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;
    logic               run;
    logic [2*WIDTH-1:0] acc_next;

    // prod is the accumulator including the current step, so the last step is usable at once
    assign acc_next = acc + (b_sh[0] ? a_sh : '0);
    assign prod     = acc_next;
    assign done     = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            run  <= 1'b0;
        end else if (start) begin
            acc  <= '0;
            a_sh <= {{WIDTH{1'b0}}, a};
            b_sh <= b;
            cnt  <= CW'(WIDTH - 1);
            run  <= 1'b1;
        end else if (run) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
// Build option: MULT_ARB_PRIO0_EN gives requester 0 absolute priority over the others.
//
// state | meaning
// IDLE  | waiting for any req; winner captured on the next edge
// RUN   | WIDTH shift-add steps on the latched operands
// DONE  | res_valid high for one cycle, then back to IDLE
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    a_in,
    input  logic [NREQ*WIDTH-1:0]    b_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     res_valid,
    output logic [2*WIDTH-1:0]       res_data,
    output logic [$clog2(NREQ)-1:0]  res_id
);

    localparam int IW = $clog2(NREQ);

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      id_q;
    logic [NREQ-1:0]    req_rr;
    logic [IW-1:0]      hi_idx;
    logic [IW-1:0]      lo_idx;
    logic               hi_found;
    logic [IW-1:0]      win_idx;
    logic               start;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] core_prod;
    logic               core_done;

    // Rotating search: lowest index above ptr wins, else lowest index at or below ptr.
    always_comb begin
        req_rr   = req;
`ifdef MULT_ARB_PRIO0_EN
        req_rr[0] = 1'b0;
`endif
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rr[i]) begin
                if (IW'(i) > ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end else begin
                    lo_idx = IW'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
`ifdef MULT_ARB_PRIO0_EN
        if (req[0]) begin
            win_idx = '0;
        end
`endif
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign start = (state == IDLE) && (|req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (core_done) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            ptr      <= IW'(NREQ - 1);
            id_q     <= '0;
            res_data <= '0;
            res_id   <= '0;
        end else begin
            gnt <= '0;
            if (start) begin
                gnt  <= NREQ'(1) << win_idx;
                id_q <= win_idx;
`ifdef MULT_ARB_PRIO0_EN
                // Requester 0 wins outside the rotation, so it must not disturb the pointer.
                if (win_idx != '0) begin
                    ptr <= win_idx;
                end
`else
                ptr <= win_idx;
`endif
            end
            if ((state == RUN) && core_done) begin
                res_data <= core_prod;
                res_id   <= id_q;
            end
        end
    end

    mult_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_sel),
        .b     (b_sel),
        .prod  (core_prod),
        .done  (core_done)
    );

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb (NREQ=4, WIDTH=4); also meaningful with MULT_ARB_PRIO0_EN.
module tb_mult_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic        busy;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mdl_last;

    typedef struct {
        logic [3:0] r;
        logic [3:0] a;
        logic [3:0] b;
        int         id;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arbitration: next requester after the last winner, or requester 0 first in priority builds.
    function automatic int mdl_pick(input logic [3:0] r);
`ifdef MULT_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (mdl_last + k) % NREQ;
`ifdef MULT_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic mdl_commit(input int w);
`ifdef MULT_ARB_PRIO0_EN
        if (w != 0) mdl_last = w;
`else
        mdl_last = w;
`endif
    endtask

    // One isolated operation; req and operands are scrambled right after the grant.
    task automatic run_op(input string tag, input logic [3:0] r, input logic [15:0] a,
                          input logic [15:0] b, input int exp_id, input logic [7:0] exp_data);
        int n;
        req  = r;
        a_in = a;
        b_in = b;
        tick();
        chk({tag, " gnt"}, 32'(gnt), 32'(4'b0001 << exp_id));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        req  = '0;
        a_in = ~a;
        b_in = ~b;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n + 1), 32'd5);
        chk({tag, " data"}, 32'(res_data), 32'(exp_data));
        chk({tag, " id"}, 32'(res_id), 32'(exp_id));
        tick();
        chk({tag, " valid_end"}, 32'(res_valid), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        mdl_commit(exp_id);
    endtask

    // Requests held high continuously: checks grant order, results and pulse spacing.
    task automatic held_seq(input string tag, input logic [3:0] r, input int cnt);
        int n;
        int w;
        int prev;
        logic [7:0] ex;
        req = r;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*4 +: 4] = 4'(i * 3);
            b_in[i*4 +: 4] = 4'd5;
        end
        prev = -1;
        for (int j = 0; j < cnt; j++) begin
            w = mdl_pick(r);
            n = 0;
            while (gnt == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("%s gnt%0d", tag, j), 32'(gnt), 32'(4'b0001 << w));
            mdl_commit(w);
            n = 0;
            while (res_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            ex = 8'(w * 15);
            chk($sformatf("%s data%0d", tag, j), 32'(res_data), 32'(ex));
            chk($sformatf("%s id%0d", tag, j), 32'(res_id), 32'(w));
            if (prev >= 0) chk($sformatf("%s spacing%0d", tag, j), 32'(cyc - prev), 32'd6);
            prev = cyc;
            tick();
        end
        req = '0;
        tick();
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa;
        logic [15:0] pb;
        logic [3:0]  r;
        logic [7:0]  ea;
        logic [7:0]  eb;
        int          w;
        int          n;

        tbl[0] = '{4'b0001, 4'd9,  4'd0,  0, 8'd0};
        tbl[1] = '{4'b0010, 4'd0,  4'd11, 1, 8'd0};
        tbl[2] = '{4'b1100, 4'd13, 4'd7,  2, 8'd91};
        tbl[3] = '{4'b1010, 4'd15, 4'd14, 3, 8'd210};
        tbl[4] = '{4'b0011, 4'd2,  4'd8,  0, 8'd16};
        tbl[5] = '{4'b0110, 4'd15, 4'd1,  1, 8'd15};
        tbl[6] = '{4'b1100, 4'd6,  4'd10, 2, 8'd60};
        tbl[7] = '{4'b1010, 4'd1,  4'd1,  3, 8'd1};

        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        mdl_last = NREQ - 1;
        tick();
        tick();
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(res_valid), 32'd0);
        chk("rst data", 32'(res_data), 32'd0);
        chk("rst id", 32'(res_id), 32'd0);
        rst = 1'b0;
        tick();

        run_op("max15x15", 4'b0001, 16'h000F, 16'h000F, 0, 8'd225);

        tick();
        tick();
        tick();
        chk("idle gnt", 32'(gnt), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle valid", 32'(res_valid), 32'd0);
        chk("idle data", 32'(res_data), 32'd225);
        chk("idle id", 32'(res_id), 32'd0);

        for (int t = 0; t < 8; t++) begin
            pa = 16'h5555;
            pb = 16'hAAAA;
            pa[tbl[t].id*4 +: 4] = tbl[t].a;
            pb[tbl[t].id*4 +: 4] = tbl[t].b;
            run_op($sformatf("tbl%0d", t), tbl[t].r, pa, pb, tbl[t].id, tbl[t].data);
        end

        held_seq("held1111", 4'b1111, 5);
        held_seq("held1110", 4'b1110, 3);

        // Operands of the granted requester change mid-flight.
        w = mdl_pick(4'b0100);
        req  = 4'b0100;
        a_in = 16'h0700;
        b_in = 16'h0600;
        tick();
        chk("midchg gnt", 32'(gnt), 32'(4'b0001 << w));
        a_in = 16'h1111;
        b_in = 16'h1111;
        req  = 4'b1111;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        req = '0;
        chk("midchg data", 32'(res_data), 32'd42);
        chk("midchg id", 32'(res_id), 32'd2);
        mdl_commit(w);
        tick();
        tick();

        for (int t = 0; t < 30; t++) begin
            r  = 4'($urandom_range(1, 15));
            pa = 16'($urandom);
            pb = 16'($urandom);
            w  = mdl_pick(r);
            ea = {4'd0, pa[w*4 +: 4]};
            eb = {4'd0, pb[w*4 +: 4]};
            run_op($sformatf("rnd%0d", t), r, pa, pb, w, ea * eb);
        end

        // Reset during RUN step 2 aborts the operation.
        req  = 4'b0010;
        a_in = 16'h0050;
        b_in = 16'h0050;
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort gnt", 32'(gnt), 32'd0);
        chk("abort valid", 32'(res_valid), 32'd0);
        chk("abort data", 32'(res_data), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort hold%0d", k), 32'(res_valid), 32'd0);
        end
        rst = 1'b0;
        mdl_last = NREQ - 1;
        tick();
        chk("post_rst valid", 32'(res_valid), 32'd0);
        run_op("post_rst", 4'b0100, 16'h0300, 16'h0400, 2, 8'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
